// File: rtl/rca_share_sequencer.sv
// rtl/rca_share_sequencer.sv - round-robin sharing of one 16-bit ripple-carry slice between two requesters
//
// Purpose:
//    Two requesters issue WORDS x 16-bit additions. An accepted request is
//    fed through a single 16-bit ripple-carry slice one word per cycle, LSW
//    first. The carry between words passes only through carry_q.
//
// Optional build macro:
//    SUB_EN - a latched sub=1 inverts B word-by-word and forces the initial
//             carry to 1, giving A-B. When SUB_EN is undefined, reqN_sub is
//             ignored and every operation is A+B+cin.
//
// Ports:
//    clk, rst                       clock (rising edge), synchronous active-high reset
//    req0_valid/ready/a/b/cin/sub   requester 0 handshake and operands
//    req1_valid/ready/a/b/cin/sub   requester 1 handshake and operands
//    resp_valid/ready               response handshake
//    resp_sum, resp_cout, resp_id   result, carry out of top word, issuing requester
//    busy                           high while an operation is in RUN or DONE

module rca16_slice (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic c;

   always_comb begin
      c   = cin;
      sum = '0;
      for (int i = 0; i < 16; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

module rca_share_sequencer #(
   parameter  int WORDS = 4,
   localparam int W     = 16 * WORDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req0_cin,
   input  logic         req0_sub,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req1_cin,
   input  logic         req1_sub,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [W-1:0] resp_sum,
   output logic         resp_cout,
   output logic         resp_id,
   output logic         busy
);

   // Keep the word index at least one bit wide so WORDS=1 still elaborates.
   localparam int              IDXW     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [IDXW-1:0] idx;
   logic            carry_q;
   logic            last_grant;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;

   logic            grant0;
   logic            grant1;
   logic            accept;
   logic            sel_cin;
   logic            start_carry;

   logic [15:0]     a_word;
   logic [15:0]     b_word;
   logic [15:0]     slice_sum;
   logic            slice_cout;

   // Round-robin: a lone valid wins; on a tie the side not granted last time wins.
   assign grant0 = req0_valid && (!req1_valid || last_grant);
   assign grant1 = req1_valid && (!req0_valid || !last_grant);
   assign accept = (state == S_IDLE) && (grant0 || grant1);

   // grant0 and grant1 are mutually exclusive, so grant1 alone selects the source.
   assign sel_cin = grant1 ? req1_cin : req0_cin;

`ifdef SUB_EN
   logic sub_q;
   logic sel_sub;

   assign sel_sub     = grant1 ? req1_sub : req0_sub;
   assign start_carry = sel_sub ? 1'b1 : sel_cin;
   assign b_word      = b_q[idx*16 +: 16] ^ {16{sub_q}};
`else
   logic unused_sub;

   assign unused_sub  = req0_sub ^ req1_sub;
   assign start_carry = sel_cin;
   assign b_word      = b_q[idx*16 +: 16];
`endif

   assign a_word = a_q[idx*16 +: 16];

   rca16_slice u_slice (
      .a    (a_word),
      .b    (b_word),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (idx == LAST_IDX) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // Returning to IDLE here means no accept can coincide with the response handshake.
            if (resp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      resp_valid = 1'b0;
      busy       = 1'b0;
      case (state)
         S_IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
         end
         S_RUN: begin
            busy = 1'b1;
         end
         S_DONE: begin
            busy       = 1'b1;
            resp_valid = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Operand capture and word-serial datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         carry_q    <= 1'b0;
         last_grant <= 1'b1;
         a_q        <= '0;
         b_q        <= '0;
         resp_sum   <= '0;
         resp_cout  <= 1'b0;
         resp_id    <= 1'b0;
`ifdef SUB_EN
         sub_q      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  a_q        <= grant1 ? req1_a : req0_a;
                  b_q        <= grant1 ? req1_b : req0_b;
                  resp_id    <= grant1;
                  last_grant <= grant1;
                  idx        <= '0;
                  carry_q    <= start_carry;
`ifdef SUB_EN
                  sub_q      <= sel_sub;
`endif
               end
            end
            S_RUN: begin
               resp_sum[idx*16 +: 16] <= slice_sum;
               carry_q                <= slice_cout;
               if (idx == LAST_IDX) begin
                  resp_cout <= slice_cout;
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
            default: begin
               // DONE holds the response stable until it is taken.
            end
         endcase
      end
   end

endmodule

// File: doc/rca_share_sequencer.md
Name: rca_share_sequencer

Overview:
- Shares one 16-bit ripple-carry adder slice between two requesters.
- Each request is a WORDS×16-bit addition. The block feeds it through the 16-bit slice one word per cycle, LSW first, with the carry chained through a register.
- Round-robin arbitration, valid/ready handshakes on both request ports and on the single response port.
- Sits between operand producers and the approximate/exact adder datapath; the adder slice is instantiated inside this block.

Parameters:
- WORDS, 4, number of 16-bit words per operand. Must be ≥1.
- W, 16*WORDS, derived operand width. Localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle when valid&&ready
- req0_a  in  W  operand A
- req0_b  in  W  operand B
- req0_cin  in  1  carry-in
- req0_sub  in  1  subtract select (used only with SUB_EN)
- req1_valid, req1_ready, req1_a, req1_b, req1_cin, req1_sub: same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_sum  out  W  result
- resp_cout  out  1  carry out of word WORDS-1
- resp_id  out  1  requester that issued the result
- busy  out  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Reset value is IDLE.
- Reset values:
  - resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0, busy=0.
  - Internal word index=0, carry reg=0, last_grant=1, so req0 wins the first tie.
- Grant (combinational, IDLE only):
  - Only one valid: that requester is granted.
  - Both valid: the requester ≠ last_grant is granted.
  - reqN_ready = (state==IDLE) && grantN. Both readys are 0 outside IDLE.
- Accept edge (IDLE, valid&&ready):
  - Latch a, b, cin, sub and id; set last_grant=id.
  - Set idx=0, carry reg=cin, go to RUN.
- RUN, each cycle:
  - Slice computes a[idx], b[idx] and the carry reg.
  - At the edge, sum word idx is written into resp_sum[16*idx+:16] and the carry reg takes the slice cout.
  - If idx==WORDS-1: go to DONE, resp_valid=1, resp_cout=slice cout. Otherwise idx++.
- Latency: resp_valid rises exactly WORDS edges after the accept edge (4 for the default). WORDS=1 gives 1 edge.
- DONE:
  - resp_sum, resp_cout and resp_id are held stable while resp_valid && !resp_ready.
  - On resp_valid && resp_ready: resp_valid=0 and go to IDLE. No accept occurs in that same cycle.
  - Minimum issue interval is WORDS+2 cycles.
- Request inputs are sampled only at the accept edge. Changes to them during RUN or DONE have no effect.
- A requester dropping valid before it is granted is legal. Nothing is latched for it.
- rst asserted in any state (including mid-RUN or DONE) aborts the operation. All outputs return to reset values at the next edge. The partial result is discarded and last_grant=1.
- Arithmetic is mod 2^W. Carry out of word k feeds word k+1 only through the register; there is no combinational chain across words.

Optional Feature:
- SUB_EN defined:
  - Latched sub=1 gives B inverted word-by-word and initial carry=1 (cin ignored), so resp_sum = A−B mod 2^W and resp_cout = 1 when A≥B (no borrow).
  - sub=0 performs a normal add.
- SUB_EN undefined: reqN_sub is ignored and every operation is A+B+cin.
- Ports are identical in both builds.

Test Plan:
- Basic add: req0 alone, a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> resp_sum=0x0000_0000_0001_0000, resp_cout=0, resp_id=0, resp_valid exactly 4 edges after accept.
- Full carry chain: req1 alone, a=0xFFFF_FFFF_FFFF_FFFF, b=0x0, cin=1 -> resp_sum=0, resp_cout=1, resp_id=1.
- Arbitration:
  - Both valid continuously from reset with resp_ready=1 -> grants alternate 0,1,0,1.
  - Only req1 valid, then both -> req0 granted next.
- Backpressure: resp_ready=0 for 10 cycles in DONE -> resp_valid, resp_sum and resp_id stable. req0_ready=req1_ready=0 throughout. Release gives IDLE one cycle later.
- Reset mid-RUN: rst at idx=2 -> next edge resp_valid=0, busy=0, resp_sum=0. Then both requesters valid -> req0 granted.
- Subtract: a=5, b=7, sub=1, cin=0.
  - With SUB_EN -> resp_sum=0xFFFF_FFFF_FFFF_FFFE, resp_cout=0.
  - Without SUB_EN -> resp_sum=12, resp_cout=0.
